// File: rtl/mult_dispatch_fifo.sv
// mult_dispatch_fifo
// Upstream feeder for the shift-and-add multiplier. Operand pairs arrive on a
// valid/ready interface and are buffered in a small FIFO. One pair at a time is
// issued to the multiplier with a single-cycle start opcode. The product is
// captured when the multiplier reports ready, and it is then presented on a
// valid/ready output. Producers therefore never see the multiplier latency.
//
// Parameters:
//   BW    operand width (product is 2*BW)
//   DEPTH operand FIFO entries, power of two, >= 2
//   CW    occupancy count width
//
// Ports:
//   clk, reset                       clock (rising edge), async active-high reset
//   in_valid/in_ready/in_a/in_b      operand pair input handshake
//   mult_multiplier/mult_multiplicand operands driven to the multiplier
//   mult_opcode                      2'b01 start pulse, 2'b00 idle
//   mult_result/mult_ready           product and idle/done flag from multiplier
//   out_valid/out_ready/out_result   product output handshake
//   fifo_count                       current FIFO occupancy
//
// Optional feature (compile-time macro MULT_DISPATCH_ZERO_BYPASS_EN):
//   A popped pair with a zero operand is answered directly with a zero product
//   and is never sent to the multiplier.

module mult_dispatch_fifo #(
  parameter int BW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   in_a,
  input  logic [BW-1:0]   in_b,
  output logic [BW-1:0]   mult_multiplier,
  output logic [BW-1:0]   mult_multiplicand,
  output logic [1:0]      mult_opcode,
  input  logic [2*BW-1:0] mult_result,
  input  logic            mult_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] out_result,
  output logic [CW-1:0]   fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BLANK = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [BW-1:0] mem_a [DEPTH];
  logic [BW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic push, pop, load_ops, capture, zero_done;

  // Ready comes from the registered count only, so a full FIFO stays not-ready
  // even in a cycle where a pop will free a slot.
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero = (mem_a[rd_ptr] == '0) || (mem_b[rd_ptr] == '0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. IDLE may issue in the same cycle the current
  // product is being accepted, keeping only one product outstanding.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    load_ops    = 1'b0;
    capture     = 1'b0;
    zero_done   = 1'b0;
    mult_opcode = 2'b00;
    case (state)
      ST_IDLE: begin
        if ((fifo_count != '0) && mult_ready && (!out_valid || out_ready)) begin
          pop = 1'b1;
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
          if (head_zero) begin
            zero_done = 1'b1;
          end else begin
            load_ops   = 1'b1;
            state_next = ST_ISSUE;
          end
`else
          load_ops   = 1'b1;
          state_next = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        mult_opcode = 2'b01;
        state_next  = ST_BLANK;
      end
      // The multiplier's ready is stale here: it only drops one cycle after it
      // samples start, so it must not be trusted until WAIT.
      ST_BLANK: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mult_ready) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers and count
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Operand registers are loaded only on issue and held through WAIT; the
  // output register is set on capture and cleared once the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
      out_valid         <= 1'b0;
      out_result        <= '0;
    end else begin
      if (load_ops) begin
        mult_multiplier   <= mem_a[rd_ptr];
        mult_multiplicand <= mem_b[rd_ptr];
      end
      if (capture) begin
        out_result <= mult_result;
        out_valid  <= 1'b1;
      end else if (zero_done) begin
        out_result <= '0;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_dispatch_fifo.sv
// Testbench for mult_dispatch_fifo.
// A behavioural multiplier answers start pulses after a configurable latency.
// A negedge scoreboard keeps the accepted pairs in queues and checks several
// things: start pulses, FIFO order, occupancy, output products and output
// hold. Directed scenarios and a randomized phase drive the block.
// Optional macro MULT_DISPATCH_ZERO_BYPASS_EN changes the expectations for
// pairs with a zero operand.

module tb_mult_dispatch_fifo;

  localparam int BW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = 2 * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic [BW-1:0] mult_multiplier, mult_multiplicand;
  logic [1:0]    mult_opcode;
  logic [PW-1:0] mult_result;
  logic          mult_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_result;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad = 0;
  int start_count = 0;
  int lat_cfg = 3;

  logic [PW-1:0] pend_q[$];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  logic          hold_pend = 1'b0;
  logic [PW-1:0] hold_val = '0;
  logic          prev_start = 1'b0;

  mult_dispatch_fifo #(.BW(BW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mult_multiplier(mult_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_opcode(mult_opcode),
    .mult_result(mult_result),
    .mult_ready(mult_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural multiplier. It samples start while idle. Ready drops on the
  // following edge. After the latency it returns the product and raises ready.
  logic          m_starting = 1'b0;
  int            m_busy = 0;
  logic [BW-1:0] m_a = '0, m_b = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_ready  <= 1'b1;
      mult_result <= '0;
      m_starting  <= 1'b0;
      m_busy      <= 0;
    end else if (m_starting) begin
      m_starting <= 1'b0;
      mult_ready <= 1'b0;
      m_busy     <= (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
    end else if (!mult_ready) begin
      if (m_busy <= 1) begin
        mult_ready  <= 1'b1;
        mult_result <= PW'(m_a) * PW'(m_b);
      end else begin
        m_busy <= m_busy - 1;
      end
    end else if (mult_opcode == 2'b01) begin
      m_starting <= 1'b1;
      m_a        <= mult_multiplier;
      m_b        <= mult_multiplicand;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic bit needsMult(input logic [BW-1:0] a, input logic [BW-1:0] b);
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
    return (a != '0) && (b != '0);
`else
    return 1'b1;
`endif
  endfunction

  // Reference model and scoreboard. Every accepted pair is owed one product,
  // in arrival order. Pairs that need the multiplier must show up as start
  // pulses in the same order. Until the head is issued, the FIFO holds exactly
  // the accepted pairs that have not been issued yet.
  always @(negedge clk) begin
    logic [PW-1:0] pr;
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
      hold_pend  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (hold_pend) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_result", out_result, hold_val);
      end
      checkOutput("opcode_legal", mult_opcode[1], 0);
      if (prev_start) begin
        checkOutput("start_single_cycle", mult_opcode, 0);
      end
      if (mult_opcode == 2'b01) begin
        start_count++;
        checkOutput("start_with_ready", mult_ready, 1);
        checkOutput("start_has_pair", pend_q.size() > 0, 1);
        if (pend_q.size() > 0) begin
          pr = pend_q.pop_front();
          checkOutput("start_a", mult_multiplier, pr[PW-1:BW]);
          checkOutput("start_b", mult_multiplicand, pr[BW-1:0]);
        end
      end
`ifndef MULT_DISPATCH_ZERO_BYPASS_EN
      checkOutput("fifo_count", fifo_count, pend_q.size());
      checkOutput("in_ready", in_ready, pend_q.size() < DEPTH);
`endif
      if (out_valid && out_ready) begin
        got_q.push_back(out_result);
        checkOutput("out_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          checkOutput("out_result", out_result, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(PW'(in_a) * PW'(in_b));
        if (needsMult(in_a, in_b)) begin
          pend_q.push_back({in_a, in_b});
        end
      end
      prev_start = (mult_opcode == 2'b01);
      hold_pend  = out_valid && !out_ready;
      hold_val   = out_result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one pair and hold it until it is accepted or the bound expires.
  task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b, input int max_wait);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < max_wait; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("push_accepted", ok, 1);
  endtask

  task automatic drainAll(input string tag);
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_count != '0 || out_valid) && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, exp_q.size() == 0 && fifo_count == '0 && !out_valid, 1);
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int s0;
    logic [PW-1:0] e3 [3];
    bit acc;

    $display("[TB] starting");

    // Reset held for two cycles, then released with no traffic.
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_fifo_count", fifo_count, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_result", out_result, 0);
      checkOutput("rst_opcode", mult_opcode, 0);
      checkOutput("rst_multiplier", mult_multiplier, 0);
      checkOutput("rst_multiplicand", mult_multiplicand, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_fifo_count", fifo_count, 0);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_opcode", mult_opcode, 0);
    end

    // Single pair 7*6 with exact issue timing, then the result held
    // until it is accepted.
    lat_cfg   = 3;
    out_ready = 1'b0;
    s0        = start_count;
    in_valid  = 1'b1;
    in_a      = 4'd7;
    in_b      = 4'd6;
    tick();
    in_valid = 1'b0;
    checkOutput("t2_opcode_after_push", mult_opcode, 0);
    checkOutput("t2_count_after_push", fifo_count, 1);
    tick();
    checkOutput("t2_opcode_issue", mult_opcode, 1);
    checkOutput("t2_issue_a", mult_multiplier, 7);
    checkOutput("t2_issue_b", mult_multiplicand, 6);
    checkOutput("t2_count_after_pop", fifo_count, 0);
    tick();
    checkOutput("t2_opcode_blank", mult_opcode, 0);
    checkOutput("t2_hold_a", mult_multiplier, 7);
    checkOutput("t2_hold_b", mult_multiplicand, 6);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t2_out_valid", out_valid, 1);
    checkOutput("t2_out_result", out_result, 42);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_held_valid", out_valid, 1);
      checkOutput("t2_held_result", out_result, 42);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t2_valid_fell", out_valid, 0);
    checkOutput("t2_start_pulses", start_count - s0, 1);

    // Three back-to-back pairs with the consumer always ready.
    got_q.delete();
    s0        = start_count;
    out_ready = 1'b1;
    applyStimulus(4'd7, 4'd6, 5);
    applyStimulus(4'd9, 4'd10, 5);
    applyStimulus(4'd15, 4'd15, 5);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    e3[0] = 8'd42;
    e3[1] = 8'd90;
    e3[2] = 8'd225;
    checkOutput("t3_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) begin
        checkOutput("t3_order", got_q[i], e3[i]);
      end
    end
    checkOutput("t3_start_pulses", start_count - s0, 3);
    drainAll("t3_drained");

    // Fill the FIFO while the consumer stalls.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(BW'(i), BW'(i + 1), 4);
    end
    checkOutput("t4_full_count", fifo_count, 4);
    checkOutput("t4_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_a     = 4'd6;
    in_b     = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    in_valid = 1'b0;
    checkOutput("t4_ignored_count", fifo_count, 4);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t4_head_valid", out_valid, 1);
    checkOutput("t4_head_result", out_result, 2);
    out_ready = 1'b1;
    tick();
    checkOutput("t4_ready_restored", in_ready, 1);
    checkOutput("t4_count_after_pop", fifo_count, 3);
    drainAll("t4_drained");

    // Reset while in WAIT with two pairs still queued.
    lat_cfg   = 8;
    out_ready = 1'b1;
    applyStimulus(4'd3, 4'd5, 5);
    applyStimulus(4'd4, 4'd5, 5);
    applyStimulus(4'd5, 4'd5, 5);
    n = 0;
    while (!(mult_ready == 1'b0 && fifo_count == CW'(2)) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t5_reached_wait", mult_ready == 1'b0 && fifo_count == CW'(2), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_rst_out_valid", out_valid, 0);
    checkOutput("t5_rst_fifo_count", fifo_count, 0);
    checkOutput("t5_rst_opcode", mult_opcode, 0);
    checkOutput("t5_rst_in_ready", in_ready, 1);
    checkOutput("t5_rst_multiplier", mult_multiplier, 0);
    tick();
    tick();
    reset = 1'b0;
    s0    = start_count;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checkOutput("t5_no_start_after", start_count - s0, 0);
    checkOutput("t5_out_valid_after", out_valid, 0);
    checkOutput("t5_count_after", fifo_count, 0);

    // A zero operand pair.
    lat_cfg   = 2;
    out_ready = 1'b0;
    s0        = start_count;
    applyStimulus(4'd0, 4'd9, 5);
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
    tick();
    checkOutput("t6_bypass_valid", out_valid, 1);
    checkOutput("t6_result", out_result, 0);
    checkOutput("t6_start_pulses", start_count - s0, 0);
`else
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t6_out_valid", out_valid, 1);
    checkOutput("t6_result", out_result, 0);
    checkOutput("t6_start_pulses", start_count - s0, 1);
`endif
    drainAll("t6_drained");

    // Randomized traffic with random multiplier latency and consumer stalls.
    lat_cfg = 0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_a     = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(0, (1 << BW) - 1));
        in_b     = BW'($urandom_range(0, (1 << BW) - 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
      end
    end
    drainAll("rand_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
